// File: rtl/calc_pkg.sv
// Shared key codes, token formats and builder state for the calculator front end.
// Output tokens are {is_num, mantissa[32:0], frac_or_code[7:0]}.
package calc_pkg;

    localparam int BUTTONS   = 26;
    localparam int DEPTH     = 12;
    localparam int WIDTH     = 8;
    localparam int NEW_WIDTH = 42;

    localparam logic [7:0] KEY_ADD    = 8'd10;
    localparam logic [7:0] KEY_SUB    = 8'd11;
    localparam logic [7:0] KEY_MUL    = 8'd12;
    localparam logic [7:0] KEY_DIV    = 8'd13;
    localparam logic [7:0] KEY_LPAREN = 8'd14;
    localparam logic [7:0] KEY_RPAREN = 8'd15;
    localparam logic [7:0] KEY_POINT  = 8'd16;
    localparam logic [7:0] KEY_E      = 8'd17;
    localparam logic [7:0] KEY_PI     = 8'd18;
    localparam logic [7:0] KEY_SIN    = 8'd19;
    localparam logic [7:0] KEY_COS    = 8'd20;
    localparam logic [7:0] KEY_TAN    = 8'd21;
    localparam logic [7:0] KEY_SQRT   = 8'd22;
    localparam logic [7:0] KEY_LN     = 8'd23;
    localparam logic [7:0] KEY_POW    = 8'd24;
    localparam logic [7:0] KEY_FACT   = 8'd25;
    localparam logic [7:0] TOK_EMPTY  = 8'hFF;

    localparam int IS_NUM    = 41;
    localparam int MANT_MSB  = 40;
    localparam int MANT_LSB  = 8;
    localparam int FRAC_MSB  = 7;
    localparam int FRAC_LSB  = 0;

    localparam logic [41:0] OUT_EMPTY = {1'b0, 33'b0, 8'hFF};

    typedef enum logic [1:0] {
        B_IDLE,
        B_SCAN,
        B_FLUSH,
        B_DONE
    } bstate_e;

    function automatic logic [41:0] pack_num(logic [32:0] m, logic [7:0] f);
        return {1'b1, m, f};
    endfunction

    function automatic logic [41:0] pack_tok(logic [7:0] t);
        return {1'b0, 33'b0, t};
    endfunction

endpackage

// File: rtl/parent_num_builder.sv
// Builder pass: walks the token buffer, merging digit/point runs into
// packed numbers and copying operator/function tokens through.
module num_builder
    import calc_pkg::*;
#(
    parameter int depth    = 12,
    parameter int width    = 8,
    parameter int newWidth = 42
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [width-1:0]    mem_i     [depth],
    output logic [newWidth-1:0] mem_out_o [depth],
    output logic                done_o,
    output logic                busy_o
);

    localparam int IW = $clog2(depth + 1);
    localparam logic [IW-1:0] ONE  = IW'(1);
    localparam logic [IW-1:0] TWO  = IW'(2);
    localparam logic [IW-1:0] LAST = IW'(depth - 1);

    bstate_e             state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IW-1:0]       out_q, out_d;
    logic [32:0]         acc_q, acc_d;
    logic [7:0]          frac_q, frac_d;
    logic                in_num_q, in_num_d;
    logic                pt_q, pt_d;
    logic [newWidth-1:0] mem_out_q [depth];
    logic [newWidth-1:0] mem_out_d [depth];
    logic [width-1:0]    tok;
    logic [IW-1:0]       out_p1;
    logic [IW-1:0]       fill_from;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        out_d     = out_q;
        acc_d     = acc_q;
        frac_d    = frac_q;
        in_num_d  = in_num_q;
        pt_d      = pt_q;
        mem_out_d = mem_out_q;
        tok       = mem_i[idx_q];
        out_p1    = out_q + ONE;
        fill_from = out_q;
        unique case (state_q)
            B_IDLE: begin
                if (start_i) begin
                    state_d  = B_SCAN;
                    idx_d    = '0;
                    out_d    = '0;
                    acc_d    = '0;
                    frac_d   = '0;
                    in_num_d = 1'b0;
                    pt_d     = 1'b0;
                end
            end
            B_SCAN: begin
                if (tok == TOK_EMPTY) begin
                    state_d = B_FLUSH;
                end else begin
                    if (tok < 8'd10) begin
                        acc_d    = acc_q * 33'd10 + 33'(tok);
                        in_num_d = 1'b1;
                        if (pt_q) frac_d = frac_q + 8'd1;
                    end else if (tok == KEY_POINT) begin
                        in_num_d = 1'b1;
                        pt_d     = 1'b1;
                    end else begin
                        if (in_num_q) begin
                            mem_out_d[out_q]  = pack_num(acc_q, frac_q);
                            mem_out_d[out_p1] = pack_tok(tok);
                            out_d = out_q + TWO;
                        end else begin
                            mem_out_d[out_q] = pack_tok(tok);
                            out_d = out_p1;
                        end
                        acc_d    = '0;
                        frac_d   = '0;
                        in_num_d = 1'b0;
                        pt_d     = 1'b0;
                    end
                    if (idx_q == LAST) state_d = B_FLUSH;
                    idx_d = idx_q + ONE;
                end
            end
            B_FLUSH: begin
                // A number still open at the end of the buffer lands first.
                if (in_num_q) begin
                    mem_out_d[out_q] = pack_num(acc_q, frac_q);
                    fill_from = out_p1;
                end
                for (int i = 0; i < depth; i++) begin
                    if (IW'(i) >= fill_from) mem_out_d[i] = OUT_EMPTY;
                end
                in_num_d = 1'b0;
                state_d  = B_DONE;
            end
            B_DONE: begin
                state_d = B_IDLE;
            end
            default: begin
                state_d = B_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= B_IDLE;
            idx_q    <= '0;
            out_q    <= '0;
            acc_q    <= '0;
            frac_q   <= '0;
            in_num_q <= 1'b0;
            pt_q     <= 1'b0;
            for (int i = 0; i < depth; i++) mem_out_q[i] <= OUT_EMPTY;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            out_q     <= out_d;
            acc_q     <= acc_d;
            frac_q    <= frac_d;
            in_num_q  <= in_num_d;
            pt_q      <= pt_d;
            mem_out_q <= mem_out_d;
        end
    end

    assign mem_out_o = mem_out_q;
    assign done_o    = (state_q == B_DONE);
    assign busy_o    = (state_q != B_IDLE);

endmodule

// File: rtl/parent.sv
// Calculator front end: keypad edge detection, editable token buffer
// with cursor, and the number builder that produces the output array.
module parent
    import calc_pkg::*;
#(
    parameter int buttons  = 26,
    parameter int depth    = 12,
    parameter int width    = 8,
    parameter int newWidth = 42
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [buttons-1:0] b,
    input  logic               del,
    input  logic               ptrLeft,
    input  logic               ptrRight,
    input  logic               eval
);

    localparam int CW = $clog2(depth + 1);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] FULL = CW'(depth);

    logic [width-1:0]    mem    [depth];
    logic [width-1:0]    mem_d  [depth];
    logic [newWidth-1:0] memOut [depth];
    logic                done;
    logic                busy;

    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       cursor_q, cursor_d;
    logic [CW-1:0]       cur_m1, cnt_m1;

    logic [buttons-1:0]  b_q;
    logic                del_q, left_q, right_q, eval_q;
    logic [buttons-1:0]  b_rise;
    logic                del_rise, left_rise, right_rise, eval_rise;
    logic                key_hit;
    logic [width-1:0]    key_code;

    assign b_rise     = b & ~b_q;
    assign del_rise   = del & ~del_q;
    assign left_rise  = ptrLeft & ~left_q;
    assign right_rise = ptrRight & ~right_q;
    assign eval_rise  = eval & ~eval_q;

    // Descending scan so the lowest rising index is the one kept.
    always_comb begin
        key_hit  = 1'b0;
        key_code = '0;
        for (int i = buttons - 1; i >= 0; i--) begin
            if (b_rise[i]) begin
                key_hit  = 1'b1;
                key_code = width'(i);
            end
        end
    end

    always_comb begin
        mem_d    = mem;
        count_d  = count_q;
        cursor_d = cursor_q;
        cur_m1   = cursor_q - ONE;
        cnt_m1   = count_q - ONE;
        if (!busy) begin
            if (key_hit) begin
                if (count_q != FULL) begin
                    for (int i = 1; i < depth; i++) begin
                        if (CW'(i) > cursor_q && CW'(i) <= count_q)
                            mem_d[i] = mem[i-1];
                    end
                    mem_d[cursor_q] = key_code;
                    count_d  = count_q + ONE;
                    cursor_d = cursor_q + ONE;
                end
            end else if (del_rise) begin
                if (cursor_q != '0) begin
                    for (int i = 0; i < depth - 1; i++) begin
                        if (CW'(i) >= cur_m1 && CW'(i) < cnt_m1)
                            mem_d[i] = mem[i+1];
                    end
                    mem_d[cnt_m1] = TOK_EMPTY;
                    count_d  = cnt_m1;
                    cursor_d = cur_m1;
                end
            end else if (left_rise) begin
                if (cursor_q != '0) cursor_d = cur_m1;
            end else if (right_rise) begin
                if (cursor_q != count_q) cursor_d = cursor_q + ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < depth; i++) mem[i] <= TOK_EMPTY;
            count_q  <= '0;
            cursor_q <= '0;
            b_q      <= '0;
            del_q    <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            eval_q   <= 1'b0;
        end else begin
            mem      <= mem_d;
            count_q  <= count_d;
            cursor_q <= cursor_d;
            b_q      <= b;
            del_q    <= del;
            left_q   <= ptrLeft;
            right_q  <= ptrRight;
            eval_q   <= eval;
        end
    end

    num_builder #(
        .depth    (depth),
        .width    (width),
        .newWidth (newWidth)
    ) u_builder (
        .clk_i     (clock),
        .rst_ni    (reset),
        .start_i   (eval_rise & ~busy),
        .mem_i     (mem),
        .mem_out_o (memOut),
        .done_o    (done),
        .busy_o    (busy)
    );

endmodule

// File: tb/tb_parent.sv
// Randomized + directed bench for the calculator front end: a token-list
// model predicts the buffer and the built output array.
module tb_parent;

    typedef logic [11:0][41:0] outarr_t;
    localparam logic [41:0] OE = {1'b0, 33'd0, 8'hFF};

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [25:0] b = '0;
    logic        del = 1'b0;
    logic        ptrLeft = 1'b0;
    logic        ptrRight = 1'b0;
    logic        eval = 1'b0;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int mbuf[$];
    int mcur = 0;
    outarr_t sb[$];

    parent dut (
        .clock    (clock),
        .reset    (reset),
        .b        (b),
        .del      (del),
        .ptrLeft  (ptrLeft),
        .ptrRight (ptrRight),
        .eval     (eval)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Monitor: each done pulse consumes one expected output array.
    always @(negedge clock) begin
        if (reset && dut.done) begin
            outarr_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                for (int i = 0; i < 12; i++)
                    chk($sformatf("memOut%0d", i), 64'(dut.memOut[i]), 64'(e[i]));
            end
        end
    end

    function automatic bit is_numc(int t);
        return (t < 10) || (t == 16);
    endfunction

    function automatic outarr_t build_ref();
        outarr_t r;
        logic [63:0] m;
        int o, i, n, fr;
        bit pt;
        o = 0; i = 0; n = mbuf.size();
        for (int k = 0; k < 12; k++) r[k] = OE;
        while (i < n) begin
            if (is_numc(mbuf[i])) begin
                m = 0; fr = 0; pt = 0;
                while (i < n && is_numc(mbuf[i])) begin
                    if (mbuf[i] == 16) pt = 1;
                    else begin
                        m = m * 64'd10 + 64'(mbuf[i]);
                        if (pt) fr++;
                    end
                    i++;
                end
                r[o] = {1'b1, m[32:0], 8'(fr)};
            end else begin
                r[o] = {1'b0, 33'd0, 8'(mbuf[i])};
                i++;
            end
            o++;
        end
        return r;
    endfunction

    task automatic chk_mem(input string tag);
        for (int i = 0; i < 12; i++)
            chk($sformatf("%s_mem%0d", tag, i), 64'(dut.mem[i]),
                64'(i < mbuf.size() ? mbuf[i] : 255));
        chk({tag, "_count"}, 64'(dut.count_q), 64'(mbuf.size()));
        chk({tag, "_cursor"}, 64'(dut.cursor_q), 64'(mcur));
    endtask

    task automatic chk_out_empty(input string tag);
        for (int i = 0; i < 12; i++)
            chk($sformatf("%s_out%0d", tag, i), 64'(dut.memOut[i]), 64'(OE));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        sb.delete();
        mbuf.delete();
        mcur = 0;
        @(negedge clock);
    endtask

    task automatic key(input int k, input int hold);
        if (mbuf.size() < 12) begin
            mbuf.insert(mcur, k);
            mcur++;
        end
        @(negedge clock);
        b[k] = 1'b1;
        repeat (hold) @(negedge clock);
        b = '0;
        @(negedge clock);
    endtask

    task automatic edit(input int kind);
        if (kind == 1 && mcur > 0) begin
            mbuf.delete(mcur - 1);
            mcur--;
        end else if (kind == 2 && mcur > 0) begin
            mcur--;
        end else if (kind == 3 && mcur < mbuf.size()) begin
            mcur++;
        end
        @(negedge clock);
        if (kind == 1) del = 1'b1;
        if (kind == 2) ptrLeft = 1'b1;
        if (kind == 3) ptrRight = 1'b1;
        @(negedge clock);
        del = 0; ptrLeft = 0; ptrRight = 0;
        @(negedge clock);
    endtask

    task automatic do_eval(input int lock_key);
        int c;
        sb.push_back(build_ref());
        @(negedge clock);
        eval = 1'b1;
        for (c = 0; c < 40 && sb.size() != 0; c++) begin
            @(negedge clock);
            if (c == 0) begin
                eval = 1'b0;
                if (lock_key >= 0) b[lock_key] = 1'b1;
            end
            if (c == 1) b = '0;
        end
        eval = 1'b0;
        b = '0;
        if (sb.size() != 0) begin
            chk("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end else begin
            chk("latency_le_15", 64'(c <= 15), 64'd1);
        end
        @(negedge clock);
    endtask

    initial begin
        int r, dbefore;
        int ex[10] = '{17, 11, 2, 16, 3, 10, 4, 16, 2, 2};
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        chk_mem("rst");
        chk_out_empty("rst");
        chk("rst_no_done", 64'(done_cnt), 64'd0);

        foreach (ex[i]) key(ex[i], 1);
        do_eval(-1);
        chk_mem("ex");
        chk("ex_done_once", 64'(done_cnt), 64'd1);
        chk("ex_out0", 64'(dut.memOut[0]), 64'({1'b0, 33'd0, 8'd17}));
        chk("ex_out2", 64'(dut.memOut[2]), 64'({1'b1, 33'd23, 8'd1}));
        chk("ex_out4", 64'(dut.memOut[4]), 64'({1'b1, 33'd422, 8'd2}));
        chk("ex_out5", 64'(dut.memOut[5]), 64'(OE));

        do_reset();
        key(1, 1); key(2, 1); key(3, 1);
        edit(2); edit(1); key(9, 1);
        chk_mem("edit");
        do_eval(-1);
        chk("edit_out0", 64'(dut.memOut[0]), 64'({1'b1, 33'd193, 8'd0}));
        chk("edit_out1", 64'(dut.memOut[1]), 64'(OE));

        do_reset();
        edit(1);
        key(5, 2); edit(3); key(6, 1);
        edit(2); edit(2); edit(1);
        chk_mem("bound");
        key(7, 10);
        chk_mem("hold10");
        // Same-cycle b bits and del: lowest b index inserted, del dropped.
        if (mbuf.size() < 12) begin
            mbuf.insert(mcur, 3);
            mcur++;
        end
        @(negedge clock);
        b[3] = 1; b[7] = 1; del = 1;
        @(negedge clock);
        b = '0; del = 0;
        @(negedge clock);
        chk_mem("prio");

        do_reset();
        for (int i = 0; i < 13; i++) key($urandom_range(0, 9), 1);
        chk_mem("full");
        key(16, 1);
        chk_mem("full2");
        do_eval(-1);

        do_reset();
        key(8, 1); key(16, 1); key(5, 1); key(12, 1);
        key(16, 1); key(7, 1); key(16, 1); key(25, 1);
        do_eval(5);
        chk_mem("lock");

        dbefore = done_cnt;
        @(negedge clock);
        eval = 1'b1;
        @(negedge clock);
        eval = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst_mem0", 64'(dut.mem[0]), 64'hFF);
        chk("midrst_out0", 64'(dut.memOut[0]), 64'(OE));
        @(negedge clock);
        reset = 1'b1;
        mbuf.delete();
        mcur = 0;
        repeat (20) @(negedge clock);
        chk("midrst_no_done", 64'(done_cnt), 64'(dbefore));
        chk_mem("midrst");
        chk_out_empty("midrst");

        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55) key($urandom_range(0, 25), $urandom_range(1, 3));
            else if (r < 67) edit(1);
            else if (r < 77) edit(2);
            else if (r < 87) edit(3);
            else begin
                do_eval(-1);
                chk_mem("rnd");
            end
        end
        do_eval(-1);
        chk_mem("end");
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parent.md
Name: parent

Overview:
- Top level of the calculator front end.
- Turns one-hot keypad presses into an editable token buffer with a cursor: insert, backspace, cursor left/right.
- On an eval press, a builder pass merges digit/decimal-point runs into packed numeric tokens and copies other tokens through.
- Result is a fixed-size output token array for the downstream evaluator.

Parameters:
- buttons, 26, keypad width (one-hot button vector).
- depth, 12, token buffer and output array entries.
- width, 8, bits per input token.
- newWidth, 42, bits per output token.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- b  input  buttons  one-hot keypad, level held while pressed.
- del  input  1  backspace key, level.
- ptrLeft  input  1  cursor-left key, level.
- ptrRight  input  1  cursor-right key, level.
- eval  input  1  start number build, level.

Required internal signal names (bench probes hierarchically):
- mem[depth][width]
- memOut[depth][newWidth]
- done

Behaviour:
- Reset (async, active-low) values:
  - every mem entry = 8'hFF (EMPTY); count = 0; cursor = 0.
  - every memOut entry = OUT_EMPTY ({1'b0, 33'b0, 8'hFF}); done = 0; builder IDLE.
- Key codes = button index:
  - 0-9 digits, 10 add, 11 sub, 12 mul, 13 div, 14 lparen, 15 rparen, 16 point, 17 e, 18 pi.
  - 19 sin, 20 cos, 21 tan, 22 sqrt, 23 ln, 24 pow, 25 fact.
- Every key input is rising-edge detected through a registered previous value. One action per press regardless of hold length.
- An action completes on the clock edge after the edge is seen.
- Several b bits rising together: lowest index wins.
- Same-cycle priority: b > del > ptrLeft > ptrRight. Lower-priority edges in that cycle are dropped.
- Insert: if count < depth, shift mem[cursor..count-1] up one, write the code at mem[cursor], then count++ and cursor++. If count == depth, ignore.
- del: if cursor > 0, remove mem[cursor-1], shift higher entries down, set the vacated top entry to EMPTY, then count-- and cursor--. If cursor == 0, no-op.
- ptrLeft: cursor-- saturating at 0. ptrRight: cursor++ saturating at count.
- Output token format:
  - Number: bit41 = 1, bits40:8 = unsigned mantissa (all digits concatenated, point removed), bits7:0 = count of digits after the point.
  - Non-number: bit41 = 0, bits40:8 = 0, bits7:0 = token code.
- Builder FSM:
  - IDLE: eval rising edge -> SCAN; idx = 0, out = 0, clear the accumulator.
  - SCAN: one mem entry per clock.
    - Digit: acc = acc*10 + d (mod 2^33); if a point was already seen, frac++. Sets inNum.
    - Point: sets inNum and seenPoint. A second point in the same run is ignored.
    - Other non-EMPTY token: if inNum, emit the number and out++. Then emit the token and out++.
    - EMPTY entry, or idx == depth-1 processed -> FLUSH.
  - FLUSH: emit any pending number; fill every remaining memOut slot with OUT_EMPTY -> DONE.
  - DONE: done = 1 for exactly one clock -> IDLE.
  - Total latency from eval edge to done ≤ depth+3 clocks.
- Number edge cases: ".5" -> mantissa 5, frac 1. "4." -> mantissa 4, frac 0. A lone "." -> mantissa 0, frac 0.
- While the builder is not IDLE, all key and eval edges are ignored and mem is frozen.
- memOut holds its last result until the next build or reset.
- Reset mid-build aborts immediately to reset values.

Decomposition:
- Package calc_pkg holds:
  - key code localparams; TOK_EMPTY = 8'hFF; OUT_EMPTY.
  - field positions: IS_NUM = 41, MANT msb/lsb = 40/8, FRAC msb/lsb = 7/0.
  - builder state enum.
- One sub-module, num_builder: the builder FSM, reading mem and writing memOut/done.
- Edge detection and the editable buffer stay in parent.

Test Plan:
- Reset then no keys: all mem = 8'hFF, all memOut = OUT_EMPTY, done never pulses.
- Keys 17,11,2,16,3,10,4,16,2,2, then eval:
  - mem0..9 = 17,11,2,16,3,10,4,16,2,2; mem10..11 = FF.
  - done pulses once.
  - memOut0 = {0,0,17}, memOut1 = {0,0,11}, memOut2 = {1,23,1}, memOut3 = {0,0,10}, memOut4 = {1,422,2}, memOut5..11 = OUT_EMPTY.
- Editing: 1,2,3, ptrLeft, del, 9:
  - mem = 1,9,3.
  - Eval gives memOut0 = {1,193,0}.
- Full buffer: 13 digit presses -> only 12 stored, count = 12. A 13th press while full changes nothing.
- Boundaries: del at cursor 0 and ptrRight at cursor == count are no-ops. b held 10 clocks inserts once.
- Busy lockout: a key press during SCAN is ignored. Async reset asserted mid-SCAN restores all reset values with no done pulse.
